// File: rtl/hazard_stall_controller.sv
// Load-use / mult-div stall and taken-branch flush sequencing for the 5-stage MIPS pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
   parameter int LOAD_STALL_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ID_EX_MemRead,
   input  logic [4:0] ID_EX_Rt,
   input  logic [4:0] IF_ID_Rs,
   input  logic [4:0] IF_ID_Rt,
   input  logic       IF_ID_UsesRt,
   input  logic       md_start,
   input  logic       md_done,
   input  logic       branch_taken,
   output logic       PC_write,
   output logic       IF_ID_write,
   output logic       IF_ID_flush,
   output logic       ID_EX_bubble,
   output logic       busy,
   output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
`endif
);

   typedef enum logic [1:0] {
      RUN        = 2'b00,
      LOAD_STALL = 2'b01,
      MD_BUSY    = 2'b10
   } state_t;

   localparam logic [3:0] LS_INIT = 4'(LOAD_STALL_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       lu;
   logic       pc_w, ifid_w, flush, bubble;

   assign lu = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
               ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pc_w      = 1'b1;
      ifid_w    = 1'b1;
      flush     = 1'b0;
      bubble    = 1'b0;
      case (state)
         RUN: begin
            // Load-use wins over branch: the branch re-resolves once the load data is forwardable.
            if (lu) begin
               pc_w   = 1'b0;
               ifid_w = 1'b0;
               bubble = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  state_nxt = LOAD_STALL;
                  cnt_nxt   = LS_INIT;
               end
            end else if (md_start) begin
               state_nxt = MD_BUSY;
            end else if (branch_taken) begin
               flush = 1'b1;
            end
         end
         LOAD_STALL: begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            bubble  = 1'b1;
            cnt_nxt = cnt - 4'd1;
            if (cnt <= 4'd1) begin
               state_nxt = RUN;
               cnt_nxt   = 4'd0;
            end
         end
         MD_BUSY: begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            bubble = 1'b1;
            if (md_done) state_nxt = RUN;
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Reset forces every control output low, independent of the registered state.
   assign PC_write     = pc_w   & ~rst;
   assign IF_ID_write  = ifid_w & ~rst;
   assign IF_ID_flush  = flush  & ~rst;
   assign ID_EX_bubble = bubble & ~rst;
   assign busy         = (state != RUN) & ~rst;
   assign state_o      = rst ? 2'b00 : state;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else if (clr_cnt) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!PC_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
         if (IF_ID_flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: one instance with single-cycle load stall, one with a 3-cycle load stall, shared stimulus.
module tb_hazard_stall_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       ID_EX_MemRead;
   logic [4:0] ID_EX_Rt, IF_ID_Rs, IF_ID_Rt;
   logic       IF_ID_UsesRt, md_start, md_done, branch_taken;

   logic       pcw1, ifw1, fl1, bub1, busy1;
   logic [1:0] st1;
   logic       pcw3, ifw3, fl3, bub3, busy3;
   logic [1:0] st3;

   int errors = 0;
   int checks = 0;

`ifdef HAZARD_PERF_CNT_EN
   logic        clr_cnt;
   logic [15:0] sc1, fc1, sc3, fc3;
`endif

   // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy, state_o}
   localparam logic [6:0] NOM    = 7'b1100000;
   localparam logic [6:0] RSTV   = 7'b0000000;
   localparam logic [6:0] STRUN  = 7'b0001000;
   localparam logic [6:0] STLS   = 7'b0001101;
   localparam logic [6:0] STMD   = 7'b0001110;
   localparam logic [6:0] FLUSH  = 7'b1110000;

   logic [6:0] o1, o3;
   assign o1 = {pcw1, ifw1, fl1, bub1, busy1, st1};
   assign o3 = {pcw3, ifw3, fl3, bub3, busy3, st3};

   hazard_stall_controller #(.LOAD_STALL_CYCLES(1)) u1 (
      .clk(clk), .rst(rst),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
      .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
      .md_start(md_start), .md_done(md_done), .branch_taken(branch_taken),
      .PC_write(pcw1), .IF_ID_write(ifw1), .IF_ID_flush(fl1),
      .ID_EX_bubble(bub1), .busy(busy1), .state_o(st1)
`ifdef HAZARD_PERF_CNT_EN
      , .clr_cnt(clr_cnt), .stall_cycles(sc1), .flush_count(fc1)
`endif
   );

   hazard_stall_controller #(.LOAD_STALL_CYCLES(3)) u3 (
      .clk(clk), .rst(rst),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
      .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
      .md_start(md_start), .md_done(md_done), .branch_taken(branch_taken),
      .PC_write(pcw3), .IF_ID_write(ifw3), .IF_ID_flush(fl3),
      .ID_EX_bubble(bub3), .busy(busy3), .state_o(st3)
`ifdef HAZARD_PERF_CNT_EN
      , .clr_cnt(clr_cnt), .stall_cycles(sc3), .flush_count(fc3)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle();
      ID_EX_MemRead = 1'b0;
      ID_EX_Rt      = 5'd0;
      IF_ID_Rs      = 5'd0;
      IF_ID_Rt      = 5'd0;
      IF_ID_UsesRt  = 1'b0;
      md_start      = 1'b0;
      md_done       = 1'b0;
      branch_taken  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
`ifdef HAZARD_PERF_CNT_EN
      clr_cnt = 1'b0;
`endif
      #12;
      chk("reset_o1", 32'(o1), 32'(RSTV));
      chk("reset_o3", 32'(o3), 32'(RSTV));
`ifdef HAZARD_PERF_CNT_EN
      chk("reset_sc1", 32'(sc1), 32'd0);
      chk("reset_fc3", 32'(fc3), 32'd0);
`endif
      rst = 1'b0;
      tick();
      mid();
      chk("idle_o1", 32'(o1), 32'(NOM));
      chk("idle_o3", 32'(o3), 32'(NOM));

      // Load-use via Rs, held for one cycle
      tick();
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8;
      mid();
      chk("lu_c0_o1", 32'(o1), 32'(STRUN));
      chk("lu_c0_o3", 32'(o3), 32'(STRUN));
      tick();
      idle();
      mid();
      chk("lu_c1_o1", 32'(o1), 32'(NOM));
      chk("lu_c1_o3", 32'(o3), 32'(STLS));
      tick();
      mid();
      chk("lu_c2_o3", 32'(o3), 32'(STLS));
      tick();
      mid();
      chk("lu_c3_o1", 32'(o1), 32'(NOM));
      chk("lu_c3_o3", 32'(o3), 32'(NOM));
`ifdef HAZARD_PERF_CNT_EN
      chk("lu_sc1", 32'(sc1), 32'd1);
      chk("lu_sc3", 32'(sc3), 32'd3);
`endif

      // False hazards
      tick();
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0;
      mid();
      chk("fh_r0_o1", 32'(o1), 32'(NOM));
      chk("fh_r0_o3", 32'(o3), 32'(NOM));
      tick();
      ID_EX_Rt = 5'd9; IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd9; IF_ID_UsesRt = 1'b0;
      mid();
      chk("fh_nort_o1", 32'(o1), 32'(NOM));
      chk("fh_nort_o3", 32'(o3), 32'(NOM));

      // Same registers but the ID instruction reads Rt: real hazard
      tick();
      IF_ID_UsesRt = 1'b1;
      mid();
      chk("lu_rt_o1", 32'(o1), 32'(STRUN));
      chk("lu_rt_o3", 32'(o3), 32'(STRUN));
      tick();
      idle();
      tick();
      tick();
      mid();
      chk("lu_rt_done_o3", 32'(o3), 32'(NOM));

      // Branch coincident with load-use: stall only
      tick();
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8; branch_taken = 1'b1;
      mid();
      chk("br_lu_o1", 32'(o1), 32'(STRUN));
      chk("br_lu_o3", 32'(o3), 32'(STRUN));
      tick();
      ID_EX_MemRead = 1'b0;
      mid();
      chk("br_flush_o1", 32'(o1), 32'(FLUSH));
      chk("br_in_ls_o3", 32'(o3), 32'(STLS));
      tick();
      idle();
      tick();
      mid();
      chk("br_after_o1", 32'(o1), 32'(NOM));
      chk("br_after_o3", 32'(o3), 32'(NOM));

      // Mult/div: issue, then done five cycles later
      tick();
      md_start = 1'b1;
      mid();
      chk("md_issue_o1", 32'(o1), 32'(NOM));
      chk("md_issue_o3", 32'(o3), 32'(NOM));
      for (int i = 1; i <= 5; i++) begin
         tick();
         md_start     = 1'b0;
         branch_taken = (i == 2);
         md_done      = (i == 5);
         mid();
         chk($sformatf("md_c%0d_o1", i), 32'(o1), 32'(STMD));
         chk($sformatf("md_c%0d_o3", i), 32'(o3), 32'(STMD));
      end
      tick();
      idle();
      mid();
      chk("md_end_o1", 32'(o1), 32'(NOM));
      chk("md_end_o3", 32'(o3), 32'(NOM));

      // Asynchronous reset in the second MD_BUSY cycle
      tick();
      md_start = 1'b1;
      tick();
      md_start = 1'b0;
      tick();
      mid();
      chk("md2_o1", 32'(o1), 32'(STMD));
      #2 rst = 1'b1;
      #1;
      chk("arst_o1", 32'(o1), 32'(RSTV));
      chk("arst_o3", 32'(o3), 32'(RSTV));
`ifdef HAZARD_PERF_CNT_EN
      chk("arst_sc1", 32'(sc1), 32'd0);
      chk("arst_sc3", 32'(sc3), 32'd0);
`endif
      #1 rst = 1'b0;
      tick();
      md_done = 1'b1;
      mid();
      chk("post_rst_o1", 32'(o1), 32'(NOM));
      chk("post_rst_o3", 32'(o3), 32'(NOM));
      tick();
      md_done = 1'b0;
      mid();
      chk("done_ignored_o1", 32'(o1), 32'(NOM));
      chk("done_ignored_o3", 32'(o3), 32'(NOM));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; pairs with the EX-stage forwarding logic.
- Handles the hazards that forwarding cannot cover:
  - load-use stalls, with a configurable memory latency;
  - multi-cycle mult/div occupancy;
  - taken-branch/jump flush of IF/ID.
- Drives the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble insert.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_Rt  input  5  load destination register in EX
- IF_ID_Rs  input  5  source register A of the instruction in ID
- IF_ID_Rt  input  5  source register B of the instruction in ID
- IF_ID_UsesRt  input  1  the ID instruction reads Rt (R-type, store, beq/bne)
- md_start  input  1  the ID instruction is mult/div and is issuing
- md_done  input  1  the mult/div unit finished (1-cycle pulse)
- branch_taken  input  1  branch/jump resolved taken in ID
- PC_write  output  1  PC register load enable
- IF_ID_write  output  1  IF/ID register load enable
- IF_ID_flush  output  1  zero IF/ID on the next edge
- ID_EX_bubble  output  1  zero ID/EX control signals on the next edge
- busy  output  1  state != RUN
- state_o  output  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=2'b00, LOAD_STALL=2'b01, MD_BUSY=2'b10. 2'b11 is illegal and recovers to RUN on the next edge.
- Internal registers: state and a 4-bit countdown cnt.
- Reset (asynchronous, immediate on rst high):
  - state=RUN, cnt=0.
  - While rst is high: PC_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=0, busy=0, state_o=0.
- Hazard term lu = ID_EX_MemRead & (ID_EX_Rt!=0) & ((ID_EX_Rt==IF_ID_Rs) | (IF_ID_UsesRt & ID_EX_Rt==IF_ID_Rt)).
- Outputs are combinational from state and inputs (zero-latency stall). Nominal values: PC_write=1, IF_ID_write=1, flush=0, bubble=0.
- RUN, priority order:
  1. lu: PC_write=0, IF_ID_write=0, ID_EX_bubble=1.
     - If LOAD_STALL_CYCLES>1: go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-1.
     - Otherwise stay in RUN.
     - branch_taken is ignored this cycle: the branch re-evaluates after the stall.
  2. md_start: mult/div issues into EX this cycle (no bubble); go to MD_BUSY.
  3. branch_taken: IF_ID_flush=1; PC_write=1.
- LOAD_STALL:
  - PC_write=0, IF_ID_write=0, ID_EX_bubble=1, and cnt decrements each cycle.
  - When cnt==1 on the edge, go to RUN.
  - lu is not re-evaluated inside LOAD_STALL.
- MD_BUSY:
  - PC_write=0, IF_ID_write=0, ID_EX_bubble=1 until md_done.
  - The md_done cycle itself still stalls; go to RUN on that edge.
  - branch_taken is ignored while in MD_BUSY.
  - md_done seen in RUN or LOAD_STALL is ignored.
- IF_ID_flush is only ever asserted in RUN with no lu. It is never asserted together with IF_ID_write=0.
- busy = (state!=RUN).
- Reset asserted mid-stall aborts the stall. The first post-reset cycle is RUN.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, add outputs:
  - stall_cycles [CNT_W-1:0]: +1 on every edge where PC_write==0 and rst==0.
  - flush_count [CNT_W-1:0]: +1 on every edge where IF_ID_flush==1.
- Both counters saturate at all-ones, clear on rst, and add a synchronous clr_cnt input (1 bit) that zeroes both on the next edge. clr_cnt has priority over increment.
- When undefined: ports absent, no counter logic, behaviour otherwise identical.

Test Plan:
- Load-use, LOAD_STALL_CYCLES=1: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 -> one cycle of PC_write=0, IF_ID_write=0, bubble=1; state stays 00; the next cycle is nominal.
- Load-use, LOAD_STALL_CYCLES=3: same stimulus (held for 1 cycle) -> exactly 3 consecutive bubble cycles, state_o 00->01->01->00, busy=1 for 2 cycles.
- False hazards:
  - ID_EX_Rt=0 with IF_ID_Rs=0 -> no stall.
  - ID_EX_Rt=9, IF_ID_Rt=9, IF_ID_UsesRt=0 -> no stall.
- Mult/div: md_start pulse, then md_done 5 cycles later -> stall for 5 cycles including the done cycle, state 10 then 00. A branch_taken during MD_BUSY gives no flush.
- Branch vs. hazard: branch_taken=1 with lu=1 -> stall only, flush=0. Next cycle branch_taken=1, lu=0 -> IF_ID_flush=1, PC_write=1.
- Async reset: assert rst in the 2nd cycle of MD_BUSY without a clock edge -> outputs immediately zero and state_o=00. After release, md_done is ignored. With HAZARD_PERF_CNT_EN, counters read 0.
